// File: rtl/mnacidpro_pkg.sv
// mnacidpro_pkg: shared types and constants for the mnacidpro purification
// sequencer: state encoding, valve bit positions, pump phase table and the
// per-state open-valve masks.
// Build option: MNACIDPRO_SEQ_FLUSH_EN adds the FLUSH state after COLLECT.
package mnacidpro_pkg;

    localparam int NUM_VALVES = 11;

    // Valve bit positions within valve/flush
    localparam int V_LYSIS     = 0;
    localparam int V_WASH      = 1;
    localparam int V_ELUTE     = 2;
    localparam int V_DEAD_END  = 3;
    localparam int V_VERTICAL  = 4;
    localparam int V_HORIZ     = 5;
    localparam int V_WASTE     = 6;
    localparam int V_BEAD      = 7;
    localparam int V_LOOP_EXIT = 8;
    localparam int V_BEAD_TRAP = 9;
    localparam int V_COLLECT   = 10;

    // Peristaltic pump phases, 1 = closed
    localparam logic [2:0] PUMP_PH0    = 3'b101;
    localparam logic [2:0] PUMP_PH1    = 3'b100;
    localparam logic [2:0] PUMP_PH2    = 3'b110;
    localparam logic [2:0] PUMP_PH3    = 3'b010;
    localparam logic [2:0] PUMP_PH4    = 3'b011;
    localparam logic [2:0] PUMP_PH5    = 3'b001;
    localparam logic [2:0] PUMP_CLOSED = 3'b111;

    // Open-valve masks (1 = open); the valve output is the inverse
    localparam logic [NUM_VALVES-1:0] OPEN_NONE    = '0;
    localparam logic [NUM_VALVES-1:0] OPEN_LOAD    = 11'((1 << V_BEAD) | (1 << V_HORIZ) | (1 << V_DEAD_END));
    localparam logic [NUM_VALVES-1:0] OPEN_LYSE    = 11'((1 << V_LYSIS) | (1 << V_VERTICAL));
    localparam logic [NUM_VALVES-1:0] OPEN_TRAP    = 11'((1 << V_BEAD_TRAP) | (1 << V_LOOP_EXIT) | (1 << V_WASTE));
    localparam logic [NUM_VALVES-1:0] OPEN_WASH    = 11'((1 << V_WASH) | (1 << V_BEAD_TRAP) | (1 << V_WASTE));
    localparam logic [NUM_VALVES-1:0] OPEN_ELUTE   = 11'((1 << V_ELUTE) | (1 << V_BEAD_TRAP) | (1 << V_VERTICAL));
    localparam logic [NUM_VALVES-1:0] OPEN_COLLECT = 11'((1 << V_LOOP_EXIT) | (1 << V_COLLECT));
    localparam logic [NUM_VALVES-1:0] OPEN_ALL     = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LYSE    = 3'd2,
        S_TRAP    = 3'd3,
        S_WASH    = 3'd4,
        S_ELUTE   = 3'd5,
`ifdef MNACIDPRO_SEQ_FLUSH_EN
        S_COLLECT = 3'd6,
        S_FLUSH   = 3'd7
`else
        S_COLLECT = 3'd6
`endif
    } state_t;

    function automatic logic [NUM_VALVES-1:0] open_mask(state_t s);
        case (s)
            S_LOAD:    return OPEN_LOAD;
            S_LYSE:    return OPEN_LYSE;
            S_TRAP:    return OPEN_TRAP;
            S_WASH:    return OPEN_WASH;
            S_ELUTE:   return OPEN_ELUTE;
            S_COLLECT: return OPEN_COLLECT;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
            S_FLUSH:   return OPEN_ALL;
`endif
            default:   return OPEN_NONE;
        endcase
    endfunction

    // Protocol order; the last step of a run returns to IDLE
    function automatic state_t next_phase(state_t s);
        case (s)
            S_LOAD:    return S_LYSE;
            S_LYSE:    return S_TRAP;
            S_TRAP:    return S_WASH;
            S_WASH:    return S_ELUTE;
            S_ELUTE:   return S_COLLECT;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
            S_COLLECT: return S_FLUSH;
`endif
            default:   return S_IDLE;
        endcase
    endfunction

    function automatic logic is_pumping(state_t s);
        return (s == S_LYSE) || (s == S_TRAP) || (s == S_ELUTE);
    endfunction

    function automatic logic [2:0] pump_code(logic [2:0] ph);
        case (ph)
            3'd0:    return PUMP_PH0;
            3'd1:    return PUMP_PH1;
            3'd2:    return PUMP_PH2;
            3'd3:    return PUMP_PH3;
            3'd4:    return PUMP_PH4;
            3'd5:    return PUMP_PH5;
            default: return PUMP_CLOSED;
        endcase
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mnacidpro_sequencer_if.sv
// mnacidpro_sequencer_if: host-side command/status bundle of the sequencer.
// Handshake: start is a request taken only on a clock edge where the
// sequencer is idle and abort is low; abort is a level taken on any edge and
// forces the sequencer back to idle; busy, done, sample_idx, valve, pump,
// flush and state are registered status from the sequencer.
interface mnacidpro_sequencer_if
    import mnacidpro_pkg::*;
#(
    parameter int SIZE = 6
);
    localparam int IDX_W = $clog2(SIZE);

    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [IDX_W-1:0]      sample_idx;
    logic [NUM_VALVES-1:0] valve;
    logic [2:0]            pump;
    logic [NUM_VALVES-1:0] flush;
    state_t                state;

    modport master (
        output start, abort,
        input  busy, done, sample_idx, valve, pump, flush, state
    );

    modport slave (
        input  start, abort,
        output busy, done, sample_idx, valve, pump, flush, state
    );

endinterface

// File: rtl/mnacidpro_pump_phaser.sv
// mnacidpro_pump_phaser: PUMP_DIV prescaler and six-phase peristaltic pump
// sequencer. restart forces phase 0 on the same edge; while en is low the
// pump valves sit closed and the sequence is parked at phase 0.
module mnacidpro_pump_phaser
    import mnacidpro_pkg::*;
#(
    parameter int PUMP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    output logic [2:0] pump
);
    localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [2:0]    phase;
    logic [2:0]    phase_nxt;

    // Wrap after the sixth phase
    always_comb begin
        phase_nxt = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    end

    // Divider, phase counter and registered pump output
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            phase   <= 3'd0;
            pump    <= PUMP_CLOSED;
        end else if (restart) begin
            div_cnt <= '0;
            phase   <= 3'd0;
            pump    <= PUMP_PH0;
        end else if (div_cnt == DW'(PUMP_DIV - 1)) begin
            div_cnt <= '0;
            phase   <= phase_nxt;
            pump    <= pump_code(phase_nxt);
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/mnacidpro_sequencer.sv
// mnacidpro_sequencer: runs one purification protocol per start request,
// stepping LOAD, LYSE, TRAP, WASH, ELUTE, COLLECT (then FLUSH when built
// with MNACIDPRO_SEQ_FLUSH_EN) for fixed cycle counts, driving the chip
// valves and pump, and advancing the collect channel after each full run.
module mnacidpro_sequencer
    import mnacidpro_pkg::*;
#(
    parameter int SIZE      = 6,
    parameter int T_LOAD    = 64,
    parameter int T_LYSE    = 256,
    parameter int T_TRAP    = 128,
    parameter int T_WASH    = 128,
    parameter int T_ELUTE   = 256,
    parameter int T_COLLECT = 64,
    parameter int T_FLUSH   = 32,
    parameter int PUMP_DIV  = 4
) (
    input  logic clk,
    input  logic rst,
    mnacidpro_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(SIZE);
    // Timer only needs to hold the longest phase length minus one
    localparam int T_MAX = max_int(max_int(max_int(T_LOAD, T_LYSE), max_int(T_TRAP, T_WASH)),
                                   max_int(max_int(T_ELUTE, T_COLLECT), T_FLUSH));
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t                state;
    state_t                succ;
    logic [TW-1:0]         timer;
    logic [IDX_W-1:0]      idx;
    logic                  busy_q;
    logic                  done_q;
    logic [NUM_VALVES-1:0] valve_q;
    logic                  last_cycle;
    logic                  pump_en;
    logic                  pump_restart;
    logic [2:0]            pump_w;

    function automatic logic [TW-1:0] phase_len(state_t s);
        case (s)
            S_LOAD:    return TW'(T_LOAD - 1);
            S_LYSE:    return TW'(T_LYSE - 1);
            S_TRAP:    return TW'(T_TRAP - 1);
            S_WASH:    return TW'(T_WASH - 1);
            S_ELUTE:   return TW'(T_ELUTE - 1);
            S_COLLECT: return TW'(T_COLLECT - 1);
`ifdef MNACIDPRO_SEQ_FLUSH_EN
            S_FLUSH:   return TW'(T_FLUSH - 1);
`endif
            default:   return '0;
        endcase
    endfunction

    // Pump control tracks the state the FSM is about to be in, so the pump
    // register switches on the same edge as the valve registers
    always_comb begin
        succ         = next_phase(state);
        last_cycle   = (state != S_IDLE) && (timer == '0);
        pump_restart = !bus.abort && last_cycle && is_pumping(succ);
        pump_en      = !bus.abort && (last_cycle ? is_pumping(succ) : is_pumping(state));
    end

`ifdef MNACIDPRO_SEQ_FLUSH_EN
    logic [NUM_VALVES-1:0] flush_q;
`endif

    // Protocol FSM with phase timer, channel counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            idx     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valve_q <= '1;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
            flush_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state   <= S_IDLE;
                timer   <= '0;
                busy_q  <= 1'b0;
                valve_q <= '1;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
                flush_q <= '0;
`endif
            end else if (state == S_IDLE) begin
                if (bus.start) begin
                    state   <= S_LOAD;
                    timer   <= phase_len(S_LOAD);
                    busy_q  <= 1'b1;
                    valve_q <= ~open_mask(S_LOAD);
                end
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end else if (succ == S_IDLE) begin
                state   <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                valve_q <= '1;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
                flush_q <= '0;
`endif
                idx     <= (idx == IDX_W'(SIZE - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                state   <= succ;
                timer   <= phase_len(succ);
                valve_q <= ~open_mask(succ);
`ifdef MNACIDPRO_SEQ_FLUSH_EN
                flush_q <= (succ == S_FLUSH) ? '1 : '0;
`endif
            end
        end
    end

    mnacidpro_pump_phaser #(
        .PUMP_DIV(PUMP_DIV)
    ) u_pump (
        .clk    (clk),
        .rst    (rst),
        .en     (pump_en),
        .restart(pump_restart),
        .pump   (pump_w)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sample_idx = idx;
    assign bus.valve      = valve_q;
    assign bus.pump       = pump_w;
    assign bus.state      = state;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    assign bus.flush      = flush_q;
`else
    assign bus.flush      = '0;
`endif

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// tb_mnacidpro_sequencer: randomized run/abort/reset stimulus for the
// purification sequencer; expected per-cycle output frames come from a
// phase-table model of the protocol and are checked by a negedge monitor.
module tb_mnacidpro_sequencer;
    localparam int SIZE = 6;
    localparam int TL   = 4;
    localparam int TF   = 3;
    localparam int PD   = 2;
    localparam int W    = 30;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    localparam int NPH  = 7;
    localparam int RUN  = 6 * TL + TF;
`else
    localparam int NPH  = 6;
    localparam int RUN  = 6 * TL;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mnacidpro_sequencer_if #(.SIZE(SIZE)) bus();

    mnacidpro_sequencer #(
        .SIZE(SIZE), .T_LOAD(TL), .T_LYSE(TL), .T_TRAP(TL), .T_WASH(TL),
        .T_ELUTE(TL), .T_COLLECT(TL), .T_FLUSH(TF), .PUMP_DIV(PD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total   = 0;
    int bad     = 0;
    int exp_idx = 0;
    bit mon_en  = 1'b0;
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    // ---------------- reference model ----------------
    function automatic logic [10:0] bit_of(int b);
        logic [10:0] one;
        one = 11'd1;
        return one << b;
    endfunction

    // Phase index: 0 LOAD, 1 LYSE, 2 TRAP, 3 WASH, 4 ELUTE, 5 COLLECT, 6 FLUSH
    function automatic logic [10:0] open_of(int p);
        case (p)
            0: return bit_of(7) | bit_of(5) | bit_of(3);
            1: return bit_of(0) | bit_of(4);
            2: return bit_of(9) | bit_of(8) | bit_of(6);
            3: return bit_of(1) | bit_of(9) | bit_of(6);
            4: return bit_of(2) | bit_of(9) | bit_of(4);
            5: return bit_of(8) | bit_of(10);
            default: return 11'h7FF;
        endcase
    endfunction

    function automatic logic [2:0] pump_seq(int n);
        case (n % 6)
            0: return 3'b101;
            1: return 3'b100;
            2: return 3'b110;
            3: return 3'b010;
            4: return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] pump_at(int p, int k);
        if (p == 1 || p == 2 || p == 4) return pump_seq(k / PD);
        return 3'b111;
    endfunction

    function automatic logic [W-1:0] mk(logic d, logic b, logic [2:0] i,
                                        logic [10:0] v, logic [2:0] p, logic [10:0] f);
        return {d, b, i, v, p, f};
    endfunction

    // Queue the first 'cut' busy frames of a run; a full run adds its done frame
    task automatic push_run(input int cut);
        int n;
        logic [2:0] cur;
        n   = 0;
        cur = 3'(exp_idx);
        for (int p = 0; p < NPH; p++) begin
            for (int k = 0; k < ((p == 6) ? TF : TL); k++) begin
                if (n < cut)
                    exp_q.push_back(mk(1'b0, 1'b1, cur, ~open_of(p), pump_at(p, k),
                                       (p == 6) ? 11'h7FF : 11'h000));
                n++;
            end
        end
        if (cut >= RUN) begin
            exp_idx = (exp_idx + 1) % SIZE;
            exp_q.push_back(mk(1'b1, 1'b0, 3'(exp_idx), 11'h7FF, 3'b111, 11'h000));
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = mk(bus.done, bus.busy, bus.sample_idx, bus.valve, bus.pump, bus.flush);
            total++;
            if (bus.busy || bus.done) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame act=%h exp=none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        bad++;
                        $display("FAIL frame act=%h exp=%h", mon_act, mon_exp);
                    end
                end
            end else if (bus.valve !== 11'h7FF || bus.pump !== 3'b111 || bus.flush !== 11'h000) begin
                bad++;
                $display("FAIL idle_outputs act=%h exp_valve=7ff pump=7 flush=0", mon_act);
            end
        end
    end

    // ---------------- driver ----------------
    // cut < RUN: stop the run (abort or rst) after 'cut' visible cycles.
    // spur >= 0: pulse start again 'spur' cycles into a full run.
    task automatic do_run(input int cut, input bit use_rst, input int spur);
        push_run(cut);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (cut < RUN) begin
            repeat (cut - 1) begin @(posedge clk); #1; end
            if (use_rst) rst = 1'b1;
            else bus.abort = 1'b1;
            @(posedge clk); #1;
            rst       = 1'b0;
            bus.abort = 1'b0;
            if (use_rst) exp_idx = 0;
            check("stop_frames_left", exp_q.size(), 0);
            exp_q.delete();
            check("stop_busy", bus.busy, 0);
            check("stop_done", bus.done, 0);
            check("stop_idx", bus.sample_idx, exp_idx);
        end else begin
            if (spur >= 0) begin
                repeat (spur) begin @(posedge clk); #1; end
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            wait_drain();
            check("run_idx", bus.sample_idx, exp_idx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int sel;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valve", bus.valve, 11'h7FF);
        check("rst_pump", bus.pump, 3'b111);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_idx", bus.sample_idx, 0);
        check("rst_flush", bus.flush, 0);
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Plain run, then abort in the second WASH cycle, then a normal run
        do_run(RUN, 1'b0, -1);
        repeat (2) begin @(posedge clk); #1; end
        do_run(3 * TL + 2, 1'b0, -1);
        do_run(RUN, 1'b0, -1);

        // start together with abort while idle must not launch a run
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_abort_busy", bus.busy, 0);

        // Randomized mix of full runs (with stray starts) and aborted runs
        for (int it = 0; it < 16; it++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            sel = $urandom_range(0, 3);
            if (sel == 0)
                do_run($urandom_range(1, RUN - 1), 1'b0, -1);
            else if ($urandom_range(0, 1) == 1)
                do_run(RUN, 1'b0, $urandom_range(0, RUN - 1));
            else
                do_run(RUN, 1'b0, -1);
        end

        // Back-to-back full runs walk sample_idx through a full wrap
        for (int it = 0; it < SIZE + 1; it++)
            do_run(RUN, 1'b0, -1);

        // Reset mid-run clears sample_idx, then a fresh run from channel 0
        do_run($urandom_range(1, RUN - 1), 1'b1, -1);
        do_run(RUN, 1'b0, -1);
        check("final_idx", bus.sample_idx, 1);

        repeat (4) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
